// File: rtl/cmp_result_pipe.sv
// Handshaked sequencing stage around a 2-bit magnitude comparator.
// Registers operands, captures the lt/gt/eq result and keeps outcome statistics.
module cmp_result_pipe #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  output logic [1:0]       cmp_a,
  output logic [1:0]       cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_gt,
  output logic             out_eq,
  output logic [1:0]       out_a,
  output logic [1:0]       out_b,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e           state_q, state_d;
  logic             capture;
  logic             in_hs, out_hs;
  logic             one_hot;
  logic [1:0]       cmp_a_q, cmp_b_q;
  logic [1:0]       out_a_q, out_b_q;
  logic [2:0]       res_q;
  logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d;
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;
  logic             err_q, err_d;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StSettle;
      end
      StSettle: begin
        capture = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        out_valid = 1'b1;
        // Downstream draining frees the operand register for a new pair this cycle
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? StSettle : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cmp_a_q <= '0;
      cmp_b_q <= '0;
      res_q   <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_hs) begin
        cmp_a_q <= in_a;
        cmp_b_q <= in_b;
      end
      if (capture) begin
        res_q   <= {cmp_lt, cmp_gt, cmp_eq};
        out_a_q <= cmp_a_q;
        out_b_q <= cmp_b_q;
      end
    end
  end

  assign one_hot = (res_q == 3'b100) || (res_q == 3'b010) || (res_q == 3'b001);

  always_comb begin
    cnt_lt_d = cnt_lt_q;
    cnt_gt_d = cnt_gt_q;
    cnt_eq_d = cnt_eq_q;
    err_d    = err_q;
    if (clr_cnt) begin
      cnt_lt_d = '0;
      cnt_gt_d = '0;
      cnt_eq_d = '0;
      err_d    = 1'b0;
    end else if (out_hs) begin
      if (res_q[2] && !(&cnt_lt_q)) cnt_lt_d = cnt_lt_q + 1'b1;
      if (res_q[1] && !(&cnt_gt_q)) cnt_gt_d = cnt_gt_q + 1'b1;
      if (res_q[0] && !(&cnt_eq_q)) cnt_eq_d = cnt_eq_q + 1'b1;
      if (!one_hot) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lt_q <= '0;
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_lt_q <= cnt_lt_d;
      cnt_gt_q <= cnt_gt_d;
      cnt_eq_q <= cnt_eq_d;
      err_q    <= err_d;
    end
  end

  assign cmp_a  = cmp_a_q;
  assign cmp_b  = cmp_b_q;
  assign out_lt = res_q[2];
  assign out_gt = res_q[1];
  assign out_eq = res_q[0];
  assign out_a  = out_a_q;
  assign out_b  = out_b_q;
  assign cnt_lt = cnt_lt_q;
  assign cnt_gt = cnt_gt_q;
  assign cnt_eq = cnt_eq_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cmp_result_pipe.sv
// Bench for cmp_result_pipe: comparator model, result scoreboard and counter model.
module tb_cmp_result_pipe;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_a = '0;
  logic [1:0]       in_b = '0;
  logic [1:0]       cmp_a, cmp_b;
  logic             cmp_lt, cmp_gt, cmp_eq;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_lt, out_gt, out_eq;
  logic [1:0]       out_a, out_b;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_lt, cnt_gt, cnt_eq;
  logic             err;

  // Comparator model with an override used to inject non-one-hot results
  logic       ovr = 1'b0;
  logic [2:0] ovr_val = '0;
  assign {cmp_lt, cmp_gt, cmp_eq} = ovr ? ovr_val : {cmp_a < cmp_b, cmp_a > cmp_b, cmp_a == cmp_b};

  always #5 clk = ~clk;

  cmp_result_pipe #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_lt    (cmp_lt),
    .cmp_gt    (cmp_gt),
    .cmp_eq    (cmp_eq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lt    (out_lt),
    .out_gt    (out_gt),
    .out_eq    (out_eq),
    .out_a     (out_a),
    .out_b     (out_b),
    .clr_cnt   (clr_cnt),
    .cnt_lt    (cnt_lt),
    .cnt_gt    (cnt_gt),
    .cnt_eq    (cnt_eq),
    .err       (err)
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] res;
  } vec_t;

  vec_t vecs[3];
  vec_t sb[$];
  vec_t e;

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] m_lt = '0, m_gt = '0, m_eq = '0;
  logic             m_err = 1'b0;
  localparam logic [CNT_W-1:0] CntMax = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard pop and counter model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_lt = '0; m_gt = '0; m_eq = '0; m_err = 1'b0;
    end else begin
      chk("cnt_lt", 32'(cnt_lt), 32'(m_lt));
      chk("cnt_gt", 32'(cnt_gt), 32'(m_gt));
      chk("cnt_eq", 32'(cnt_eq), 32'(m_eq));
      chk("err", 32'(err), 32'(m_err));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got result %b with no pair pending", {out_lt, out_gt, out_eq});
        end else begin
          e = sb.pop_front();
          chk("out_res", 32'({out_lt, out_gt, out_eq}), 32'(e.res));
          chk("out_a", 32'(out_a), 32'(e.a));
          chk("out_b", 32'(out_b), 32'(e.b));
          if (e.res[2] && m_lt != CntMax) m_lt = m_lt + 1'b1;
          if (e.res[1] && m_gt != CntMax) m_gt = m_gt + 1'b1;
          if (e.res[0] && m_eq != CntMax) m_eq = m_eq + 1'b1;
          if (!(e.res inside {3'b100, 3'b010, 3'b001})) m_err = 1'b1;
        end
      end
      if (clr_cnt) begin
        m_lt = '0; m_gt = '0; m_eq = '0; m_err = 1'b0;
      end
    end
  end

  // Drives a pair until accepted; leaves in_valid high so calls can stream back to back
  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [2:0] res);
    int  n = 0;
    bit  hs = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        hs = 1;
        sb.push_back('{a: a, b: b, res: res});
      end
      @(posedge clk);
      n++;
    end
    #1;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{a: 2'd1, b: 2'd1, res: 3'b001};
    vecs[1] = '{a: 2'd3, b: 2'd0, res: 3'b010};
    vecs[2] = '{a: 2'd0, b: 2'd2, res: 3'b100};

    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_cmp_a", 32'(cmp_a), 0);
    chk("rst_out_res", 32'({out_lt, out_gt, out_eq}), 0);
    chk("rst_cnt", 32'({cnt_lt, cnt_gt, cnt_eq, err}), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // 1: latency of two edges, gt result
    out_ready = 1'b1;
    send(2'd2, 2'd1, 3'b010);
    in_valid = 1'b0;
    chk("t1_not_yet_valid", 32'(out_valid), 0);
    chk("t1_cmp_a", 32'(cmp_a), 2);
    cyc();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_gt", 32'({out_lt, out_gt, out_eq}), 32'(3'b010));
    chk("t1_out_a", 32'(out_a), 2);
    chk("t1_out_b", 32'(out_b), 1);
    cyc();
    chk("t1_cnt_gt", 32'(cnt_gt), 1);
    chk("t1_idle", 32'(out_valid), 0);

    // 2: backpressure holds the lt result stable
    out_ready = 1'b0;
    send(2'd0, 2'd3, 3'b100);
    in_valid = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(out_valid), 1);
      chk("t2_res", 32'({out_lt, out_gt, out_eq}), 32'(3'b100));
      chk("t2_ab", 32'({out_a, out_b}), 32'(4'b0011));
      chk("t2_in_ready", 32'(in_ready), 0);
      chk("t2_cnt_lt", 32'(cnt_lt), 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("t2_cnt_lt_after", 32'(cnt_lt), 1);

    // 3: streaming table
    for (int i = 0; i < 3; i++) send(vecs[i].a, vecs[i].b, vecs[i].res);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("t3_drained", 32'(sb.size()), 0);
    chk("t3_cnts", 32'({cnt_lt, cnt_gt, cnt_eq}), 32'({8'd2, 8'd2, 8'd1}));

    // 4: non-one-hot result, sticky err, clear
    ovr = 1'b1;
    ovr_val = 3'b101;
    send(2'd1, 2'd2, 3'b101);
    in_valid = 1'b0;
    cyc();
    ovr = 1'b0;
    cyc();
    chk("t4_err", 32'(err), 1);
    chk("t4_cnt_lt", 32'(cnt_lt), 3);
    chk("t4_cnt_eq", 32'(cnt_eq), 2);
    send(2'd2, 2'd2, 3'b001);
    in_valid = 1'b0;
    repeat (2) cyc();
    chk("t4_err_sticky", 32'(err), 1);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("t4_clr", 32'({cnt_lt, cnt_gt, cnt_eq, err}), 0);

    // 5: saturation
    for (int i = 0; i < 300; i++) send(2'(i % 4), 2'(i % 4), 3'b001);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("t5_sat", 32'(cnt_eq), 255);
    chk("t5_drained", 32'(sb.size()), 0);

    // 6: reset during SETTLE
    send(2'd1, 2'd2, 3'b100);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_cmp_a", 32'(cmp_a), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    send(2'd3, 2'd3, 3'b001);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("t6_drained", 32'(sb.size()), 0);
    chk("t6_cnt_eq", 32'(cnt_eq), 1);
    chk("t6_cnt_lt", 32'(cnt_lt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
